auth_msg_chunker: RTL
=====================

# auth_msg_chunker

Downstream transmit stage for the authentication driver. It accepts one complete authentication message word through a ready/ack handshake and splits it into USB-PD extended-message chunks of at most 26 data bytes. Each chunk is prefixed with a 2-byte extended header and is streamed byte-by-byte over a valid/ready interface toward the PD PHY model. It is the consumer of `auth_msg_out` / `auth_msg_ready`.

## Interface
- `MSG_BYTES`, default `` `MSG_LEN/8 ``: capacity in bytes of the message word. `` `MSG_LEN `` is a multiple of 8. Elaboration requires `MSG_BYTES <= 416`, i.e. at most 16 chunks.
- `CHUNK_BYTES`, default 26: maximum data bytes per chunk. Range 1..26.
- `clk` in 1: the single clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-low. `reset==0` at a rising edge resets the block.
- `msg_in` in `` `MSG_LEN ``: message word. Byte k is `msg_in[8k+7:8k]`; byte 0 is sent first.
- `msg_len` in 9: number of valid bytes, sampled together with `msg_in`.
- `msg_ready` in 1: the producer has a message available.
- `msg_ack` out 1: one-cycle pulse when the message has been captured.
- `msg_err` out 1: one-cycle pulse, coincident with `msg_ack`, when the length is illegal.
- `tx_data` out 8: output byte.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: the sink accepts the byte. A byte transfers when `tx_valid && tx_ready`.
- `tx_sop` out 1: marks the first byte of a chunk (header byte 0).
- `tx_eop` out 1: marks the last byte of a chunk.
- `busy` out 1: high from capture until the last byte of the last chunk has transferred.

## Operation
- States: IDLE, HDR0, HDR1, DATA, CSUM (only when the macro is enabled), and ERR.
- **IDLE:**
  - If `msg_ready==1`, capture `msg_in` and `msg_len`, and reset the byte index and chunk index to 0.
  - If `1 <= msg_len <= MSG_BYTES`, go to HDR0. Otherwise go to ERR.
- **ERR:** pulse `msg_ack` and `msg_err` for one cycle, produce no output, and return to IDLE.
- **HDR0:** emit `msg_len[7:0]`.
- **HDR1:** emit `{1'b1, chunk[3:0], 2'b00, msg_len[8]}`. This is PD extended header bit 15 (chunked), bits 14:11 (chunk number), with request-chunk and reserved bits at 0, and bit 8 (size MSB).
- **DATA:**
  - Emit captured bytes in order. The chunk size is `min(CHUNK_BYTES, msg_len - bytes_sent)`.
  - After the last byte of the chunk: go to CSUM if enabled. Otherwise, if bytes remain, increment `chunk` and go to HDR0; if none remain, go to IDLE.
- States advance only on a transfer. While `tx_ready==0`, `tx_data`, `tx_sop` and `tx_eop` hold their values.
- Number of chunks is `ceil(msg_len/CHUNK_BYTES)`. Chunk indices run 0..N-1 and never wrap, given the `MSG_BYTES` limit.
- `msg_ready` is ignored while `busy==1`. The producer must keep `msg_ready` high until it sees `msg_ack`.

## Timing
- Reset values: `msg_ack`, `msg_err`, `tx_valid`, `tx_sop`, `tx_eop` and `busy` are 0; `tx_data` is 8'h00; state is IDLE; all counters are 0.
- `msg_ready` sampled in IDLE at edge T gives:
  - `msg_ack` high during cycle T+1, for exactly one cycle.
  - `busy` and `tx_valid` high from T+1, with the first header byte presented at T+1.
- With `tx_ready` held at 1, bytes are back-to-back with no gap between chunks. `tx_valid` drops in the cycle after the final transfer.
- `busy` falls in the same cycle as `tx_valid`. A new message can be captured in the first IDLE cycle, so message-to-message spacing is 1 idle cycle.
- Reset asserted mid-message: at the next edge all outputs return to reset values and the captured message is discarded. No `msg_ack` is issued for a message that was not yet acknowledged.

## Configuration
- `AUTH_CHUNK_CHECKSUM_EN`:
  - **Defined:** after each chunk's data, emit one CSUM byte, equal to the two's complement of the 8-bit sum of that chunk's header and data bytes, so that all chunk bytes sum to 0 mod 256. `tx_eop` marks the CSUM byte.
  - **Undefined:** the CSUM state and its accumulator are absent, and `tx_eop` marks the last data byte.

## Structure
- Shared package/include, next to `Parameters.v`, holds:
  - `` `MSG_LEN ``.
  - `` `PD_CHUNK_BYTES `` (26).
  - State encodings.
  - Extended-header bit positions: `CHUNKED=15`, `CHUNK_NUM=14:11`, `REQ_CHUNK=10`, `SIZE=8:0`.
- One sub-module, `auth_byte_mux`: a combinational selector of captured byte k from the message register, parameterised on `MSG_BYTES`.

## Test plan
- `msg_len=4`, `msg_in[31:0]=32'h44332211`, `tx_ready=1` → `msg_ack` at T+1; bytes `04 80 11 22 33 44`. With `AUTH_CHUNK_CHECKSUM_EN`, followed by `D2`. `tx_sop` on `04`, `tx_eop` on the last byte.
- `msg_len=30` → chunk 0 is `1E 80` + 26 bytes; chunk 1 is `1E 88` + 4 bytes; two `sop`/`eop` pairs and no gap.
- `tx_ready` toggled 1-0-0-1 in the middle of DATA → `tx_data` stable while stalled; no byte duplicated or dropped.
- `msg_len=0`, then `msg_len=MSG_BYTES+1` → `msg_ack` and `msg_err` pulse together; `tx_valid` stays 0.
- `reset=0` for one cycle during chunk 1 → all outputs reset at the next edge. A new message with `msg_len=1` then gives `01 80 xx`.
- Second `msg_ready` while `busy` → not acknowledged until the first message completes; then captured 1 cycle later.

Source files
------------

// File: rtl/auth_msg_chunker_pkg.sv
// Shared definitions for the authentication message chunker.
// Optional feature macro: AUTH_CHUNK_CHECKSUM_EN (per-chunk checksum byte).
// MSG_LEN and PD_CHUNK_BYTES may be overridden on the command line.

`ifndef MSG_LEN
`define MSG_LEN 256
`endif

`ifndef PD_CHUNK_BYTES
`define PD_CHUNK_BYTES 26
`endif

package auth_msg_chunker_pkg;

  localparam int MSG_LEN_BITS   = `MSG_LEN;
  localparam int PD_CHUNK_BYTES = `PD_CHUNK_BYTES;
  localparam int MAX_MSG_BYTES  = 416;

  // PD extended message header bit positions
  localparam int HDR_CHUNKED       = 15;
  localparam int HDR_CHUNK_NUM_MSB = 14;
  localparam int HDR_CHUNK_NUM_LSB = 11;
  localparam int HDR_REQ_CHUNK     = 10;
  localparam int HDR_SIZE_MSB      = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR0 = 3'd1,
    S_HDR1 = 3'd2,
    S_DATA = 3'd3,
    S_ERR  = 3'd4
`ifdef AUTH_CHUNK_CHECKSUM_EN
    , S_CSUM = 3'd5
`endif
  } state_e;

  // Builds the 16-bit extended header for a transmitted chunk.
  // Request-chunk and the reserved bit 9 are always 0 on transmit.
  function automatic logic [15:0] ext_header(input logic [3:0] chunk,
                                             input logic [8:0] size);
    logic [15:0] h;
    h = '0;
    h[HDR_CHUNKED]                             = 1'b1;
    h[HDR_CHUNK_NUM_MSB:HDR_CHUNK_NUM_LSB]     = chunk;
    h[HDR_REQ_CHUNK]                           = 1'b0;
    h[HDR_SIZE_MSB:0]                          = size;
    return h;
  endfunction

endpackage

// File: rtl/auth_msg_chunker_if.sv
// Message-in / byte-stream-out bundle for the authentication chunker.
// slave: the chunker's view; master: the producer/sink environment view.

interface auth_msg_chunker_if;
  import auth_msg_chunker_pkg::*;

  logic [MSG_LEN_BITS-1:0] msg_in;
  logic [8:0]              msg_len;
  logic                    msg_ready;
  logic                    msg_ack;
  logic                    msg_err;
  logic [7:0]              tx_data;
  logic                    tx_valid;
  logic                    tx_ready;
  logic                    tx_sop;
  logic                    tx_eop;
  logic                    busy;

  modport slave (
    input  msg_in, msg_len, msg_ready, tx_ready,
    output msg_ack, msg_err, tx_data, tx_valid, tx_sop, tx_eop, busy
  );

  modport master (
    output msg_in, msg_len, msg_ready, tx_ready,
    input  msg_ack, msg_err, tx_data, tx_valid, tx_sop, tx_eop, busy
  );

endinterface

// File: rtl/auth_byte_mux.sv
// Combinational selector of captured message byte idx.

module auth_byte_mux #(
  parameter int MSG_BYTES = 32
) (
  input  logic [MSG_BYTES*8-1:0] msg,
  input  logic [8:0]             idx,
  output logic [7:0]             byte_out
);

  // Select byte idx; out-of-range indices read as zero.
  always_comb begin
    byte_out = '0;
    for (int unsigned k = 0; k < MSG_BYTES; k++) begin
      if (idx == k[8:0]) byte_out = msg[k*8 +: 8];
    end
  end

endmodule

// File: rtl/auth_msg_chunker.sv
// Splits one captured authentication message into PD extended-message
// chunks (2-byte header + up to CHUNK_BYTES data bytes) streamed bytewise.
// Optional: AUTH_CHUNK_CHECKSUM_EN appends a two's-complement checksum byte
// to each chunk.

module auth_msg_chunker
  import auth_msg_chunker_pkg::*;
#(
  parameter int MSG_BYTES   = MSG_LEN_BITS / 8,
  parameter int CHUNK_BYTES = PD_CHUNK_BYTES
) (
  input logic               clk,
  input logic               reset,
  auth_msg_chunker_if.slave bus
);

  if (MSG_BYTES < 1 || MSG_BYTES > MAX_MSG_BYTES || MSG_BYTES * 8 > MSG_LEN_BITS)
  begin : g_bad_msg_bytes
    $error("auth_msg_chunker: MSG_BYTES out of range");
  end
  if (CHUNK_BYTES < 1 || CHUNK_BYTES > 26) begin : g_bad_chunk_bytes
    $error("auth_msg_chunker: CHUNK_BYTES out of range");
  end

  localparam logic [8:0] MAX_LEN    = 9'(MSG_BYTES);
  localparam logic [4:0] CHUNK_LAST = 5'(CHUNK_BYTES - 1);

  state_e                 state_q, state_d;
  logic [MSG_BYTES*8-1:0] msg_q;
  logic [8:0]             len_q;
  logic [8:0]             idx_q;
  logic [3:0]             chunk_q;
  logic [4:0]             cnt_q;
  logic                   ack_q;

  logic                   xfer;
  logic                   len_ok;
  logic                   chunk_last;
  logic                   more_after_data;
  logic                   more_after_csum;
  logic                   next_chunk;
  logic [7:0]             data_byte;
  logic [15:0]            hdr;

`ifdef AUTH_CHUNK_CHECKSUM_EN
  logic [7:0]             csum_q;
`endif

  auth_byte_mux #(
    .MSG_BYTES (MSG_BYTES)
  ) u_byte_mux (
    .msg      (msg_q),
    .idx      (idx_q),
    .byte_out (data_byte)
  );

  assign xfer            = bus.tx_valid && bus.tx_ready;
  assign len_ok          = (bus.msg_len != 9'd0) && (bus.msg_len <= MAX_LEN);
  assign hdr             = ext_header(chunk_q, len_q);
  assign chunk_last      = (cnt_q == CHUNK_LAST) || (idx_q == len_q - 9'd1);
  assign more_after_data = (idx_q + 9'd1) < len_q;
  // In CSUM the byte index has already moved past the chunk's data.
  assign more_after_csum = idx_q < len_q;
  assign next_chunk      = xfer && (state_q != S_HDR0) && (state_q != S_HDR1)
                           && (state_d == S_HDR0);
  assign bus.msg_ack     = ack_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and stream outputs; outputs depend only on registered state,
  // so they hold naturally while the sink stalls.
  always_comb begin
    state_d      = state_q;
    bus.tx_valid = 1'b0;
    bus.tx_sop   = 1'b0;
    bus.tx_eop   = 1'b0;
    bus.tx_data  = '0;
    bus.msg_err  = 1'b0;
    bus.busy     = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (bus.msg_ready) state_d = len_ok ? S_HDR0 : S_ERR;
      end
      S_HDR0: begin
        bus.tx_valid = 1'b1;
        bus.tx_sop   = 1'b1;
        bus.tx_data  = hdr[7:0];
        if (bus.tx_ready) state_d = S_HDR1;
      end
      S_HDR1: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = hdr[15:8];
        if (bus.tx_ready) state_d = S_DATA;
      end
      S_DATA: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = data_byte;
`ifdef AUTH_CHUNK_CHECKSUM_EN
        if (bus.tx_ready && chunk_last) state_d = S_CSUM;
`else
        bus.tx_eop   = chunk_last;
        if (bus.tx_ready && chunk_last) state_d = more_after_data ? S_HDR0 : S_IDLE;
`endif
      end
`ifdef AUTH_CHUNK_CHECKSUM_EN
      S_CSUM: begin
        bus.tx_valid = 1'b1;
        bus.tx_eop   = 1'b1;
        bus.tx_data  = (~csum_q) + 8'd1;
        if (bus.tx_ready) state_d = more_after_csum ? S_HDR0 : S_IDLE;
      end
`endif
      S_ERR: begin
        bus.msg_err = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Message capture, acknowledge pulse and byte/chunk counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ack_q   <= 1'b0;
      msg_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      chunk_q <= '0;
      cnt_q   <= '0;
    end else begin
      ack_q <= 1'b0;
      if (state_q == S_IDLE && bus.msg_ready) begin
        ack_q   <= 1'b1;
        msg_q   <= bus.msg_in[MSG_BYTES*8-1:0];
        len_q   <= bus.msg_len;
        idx_q   <= '0;
        chunk_q <= '0;
        cnt_q   <= '0;
      end
      if (xfer && state_q == S_DATA) begin
        idx_q <= idx_q + 9'd1;
        cnt_q <= cnt_q + 5'd1;
      end
      if (next_chunk) begin
        chunk_q <= chunk_q + 4'd1;
        cnt_q   <= '0;
      end
    end
  end

`ifdef AUTH_CHUNK_CHECKSUM_EN
  // Running 8-bit sum of the current chunk's header and data bytes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      csum_q <= '0;
    end else if (xfer) begin
      if (state_q == S_HDR0)                          csum_q <= bus.tx_data;
      else if (state_q == S_HDR1 || state_q == S_DATA) csum_q <= csum_q + bus.tx_data;
    end
  end
`endif

endmodule
